sent_tx_data_unpack: RTL and testbench
======================================

Name: sent_tx_data_unpack

Overview:
- Parametrised byte-to-word unpacker for the SENT transmitter: one instance serves NUM_CH fast channels, each fed by its own byte FIFO.
- Each channel packs a continuous MSB-first bit stream into words of a run-time width (BYTE_W..MAX_W bits) and presents them to the frame builder over a valid/ready handshake.
- Supersedes fixed per-mode load strobes with a generic bit accumulator, backpressure, an enable/flush control and a config error flag.

Parameters:
- NUM_CH, 2, number of independent channels.
- BYTE_W, 8, FIFO byte width.
- MAX_W, 16, maximum word width.
- ACC_W, 24, accumulator bits per channel; must be >= MAX_W+BYTE_W.
- CFG_W, 5, width of each per-channel width field.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  NUM_CH  per-channel run enable.
- cfg_width  in  NUM_CH*CFG_W  per-channel word width; channel c at [c*CFG_W +: CFG_W].
- fifo_empty  in  NUM_CH  per-channel FIFO empty.
- fifo_data  in  NUM_CH*BYTE_W  per-channel FIFO read data, valid 1 cycle after read_enable.
- read_enable  out  NUM_CH  per-channel FIFO pop, single-cycle pulses.
- data_out  out  NUM_CH*MAX_W  per-channel word, right-justified, upper bits zero.
- data_valid  out  NUM_CH  word available.
- data_ready  in  NUM_CH  consumer accepts word.
- cfg_err  out  NUM_CH  one-cycle pulse on illegal width at enable rise.

Behaviour:
- Reset (reset=0): all outputs 0, accumulators cleared, fill counts 0, no read pending, latched widths = MAX_W.
- Width latch: cfg_width is sampled on the cycle enable rises 0->1.
  - Legal range is BYTE_W..MAX_W.
  - An out-of-range value latches MAX_W and pulses cfg_err for 1 cycle.
  - cfg_width changes while enable=1 are ignored.
- Per-channel state: acc[ACC_W], fill[0..ACC_W], pend (a read was issued last cycle), out_reg, data_valid.
- Read issue: read_enable=1 when enable && !fifo_empty && (fill + pend*BYTE_W) < width.
  - Throughput is at most one pop per cycle.
  - The FIFO read latency is fixed at 1 cycle.
- Capture: on the cycle after read_enable (pend=1), fifo_data is appended below the existing bits and fill += BYTE_W. Stream order is MSB-first: the first byte is the top of the first word.
- Extract: when fill >= width and (!data_valid || data_ready):
  - the oldest width bits load into data_out;
  - data_valid is set;
  - fill -= width.
  - Extract latency is 1 cycle after the capture that completes the word.
- Simultaneous extract and capture in one cycle: the result is fill - width + BYTE_W, and the bit order is preserved.
- Handshake: a transfer occurs when data_valid && data_ready.
  - data_out and data_valid stay stable while data_ready=0.
  - data_valid drops after a transfer unless a new word loads in the same cycle.
  - Back-to-back words are allowed.
- Residue: leftover bits (e.g. 2 bits after a 14-bit word from 2 bytes) are carried into the next word. No bits are ever dropped while enable=1.
- Disable (enable 1->0):
  - read_enable is forced 0 the same cycle.
  - A pending byte arriving next cycle is discarded.
  - acc and fill are cleared.
  - A word already in data_out is kept until accepted; no new word is produced.
- fifo_empty asserted mid-word: the channel stalls with partial fill and resumes without loss.
- Reset asserted mid-operation: immediate return to reset values; the pending byte is lost.
- Channels are fully independent; there is no shared arbitration.

Decomposition:
- Package sent_tx_pkg holds:
  - BYTE_W, MAX_W, ACC_W defaults;
  - the legal width range constants;
  - a helper function for the width-legality check.
- Sub-module sent_tx_unpack_ch implements one channel (accumulator, read logic, output register).
- The top generates NUM_CH instances and slices the flattened buses.

Test Plan:
- Width 14, FIFO bytes A5 3C, data_ready=1 -> two read_enable pulses; data_out=0x294F, valid 1 cycle; residue fill=2.
- Width 12, bytes 12 34 56 -> words 0x123 then 0x456; fill returns to 0; only 3 pops issued.
- Width 10, bytes FF 00 FF 00 FF -> words 0x3FC, 0x00F, 0x3C0, 0x0FF in order, no extra pops.
- Width 16, data_ready held 0 for 10 cycles after first word 0xBEEF -> data_out stays 0xBEEF; reads stop at fill>=16; the second word appears the cycle after ready rises.
- cfg_width=20 at enable rise -> cfg_err pulses once; channel runs at width 16. Channel 1 at width 8 runs concurrently, passing bytes unchanged.
- Deassert enable while read pending, then reset low mid-word -> pending byte discarded, fill=0; after reset all outputs are 0 and read_enable stays 0.

Source files
------------

// File: rtl/sent_tx_pkg.sv
// Shared defaults and width-legality helper for the SENT transmitter unpacker.
package sent_tx_pkg;

  localparam int unsigned BYTE_W_DEF = 8;
  localparam int unsigned MAX_W_DEF  = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned CFG_W_DEF  = 5;

  localparam int unsigned WIDTH_MIN  = BYTE_W_DEF;
  localparam int unsigned WIDTH_MAX  = MAX_W_DEF;

  function automatic logic width_legal(input int unsigned w,
                                       input int unsigned lo = WIDTH_MIN,
                                       input int unsigned hi = WIDTH_MAX);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/sent_tx_unpack_ch.sv
// One unpacker channel: byte FIFO reader, MSB-first bit accumulator and
// valid/ready output register.
module sent_tx_unpack_ch
  import sent_tx_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEF,
  parameter int unsigned MAX_W  = MAX_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CFG_W  = CFG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CFG_W-1:0]  cfg_width,
  input  logic              fifo_empty,
  input  logic [BYTE_W-1:0] fifo_data,
  output logic              read_enable,
  output logic [MAX_W-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              cfg_err
);

  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]  acc, acc_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic [FILL_W-1:0] width_q, width_eff, cfg_sel;
  logic [FILL_W:0]   demand;
  logic [MAX_W-1:0]  mask, word;
  logic              pend, en_d, alive, rise, cfg_ok;
  logic              do_extract, do_capture;

  assign rise      = enable && !en_d;
  assign cfg_ok    = width_legal(32'(cfg_width), BYTE_W, MAX_W);
  assign cfg_sel   = cfg_ok ? FILL_W'(cfg_width) : FILL_W'(MAX_W);
  // On the rising cycle the new width is not yet latched, so use it directly.
  assign width_eff = rise ? cfg_sel : width_q;

  // Bits already held plus the byte still in flight decide whether to pop.
  assign demand      = {1'b0, fill} + (pend ? (FILL_W+1)'(BYTE_W) : '0);
  assign read_enable = alive && enable && !fifo_empty && (demand < {1'b0, width_eff});

  assign do_extract = enable && (fill >= width_q) && (!data_valid || data_ready);
  assign do_capture = enable && pend;

  // Oldest bits sit at acc[fill-1]; shift them down to the bottom of the word.
  assign mask = ~({MAX_W{1'b1}} << width_q);
  assign word = MAX_W'(acc >> (fill - width_q)) & mask;

  always_comb begin
    acc_n  = acc;
    fill_n = fill;
    if (!enable) begin
      acc_n  = '0;
      fill_n = '0;
    end else begin
      if (do_extract) fill_n = fill - width_q;
      if (do_capture) begin
        acc_n  = {acc[ACC_W-BYTE_W-1:0], fifo_data};
        fill_n = fill_n + FILL_W'(BYTE_W);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      fill       <= '0;
      pend       <= 1'b0;
      en_d       <= 1'b0;
      alive      <= 1'b0;
      width_q    <= FILL_W'(MAX_W);
      data_out   <= '0;
      data_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      acc     <= acc_n;
      fill    <= fill_n;
      pend    <= read_enable;
      en_d    <= enable;
      alive   <= 1'b1;
      cfg_err <= rise && !cfg_ok;
      if (rise) width_q <= cfg_sel;
      if (do_extract) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sent_tx_data_unpack.sv
// Multi-channel byte-to-word unpacker: one independent channel per fast
// channel, flattened buses sliced per instance.
module sent_tx_data_unpack
  import sent_tx_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned BYTE_W = BYTE_W_DEF,
  parameter int unsigned MAX_W  = MAX_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CFG_W  = CFG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH*CFG_W-1:0]  cfg_width,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*BYTE_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        read_enable,
  output logic [NUM_CH*MAX_W-1:0]  data_out,
  output logic [NUM_CH-1:0]        data_valid,
  input  logic [NUM_CH-1:0]        data_ready,
  output logic [NUM_CH-1:0]        cfg_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sent_tx_unpack_ch #(
      .BYTE_W (BYTE_W),
      .MAX_W  (MAX_W),
      .ACC_W  (ACC_W),
      .CFG_W  (CFG_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable[c]),
      .cfg_width   (cfg_width[c*CFG_W +: CFG_W]),
      .fifo_empty  (fifo_empty[c]),
      .fifo_data   (fifo_data[c*BYTE_W +: BYTE_W]),
      .read_enable (read_enable[c]),
      .data_out    (data_out[c*MAX_W +: MAX_W]),
      .data_valid  (data_valid[c]),
      .data_ready  (data_ready[c]),
      .cfg_err     (cfg_err[c])
    );
  end

endmodule

// File: tb/tb_sent_tx_data_unpack.sv
// Bench for sent_tx_data_unpack: directed vector table, hand-written corner
// sequences and randomized streams checked against a bit-stream model.
module tb_sent_tx_data_unpack;

  localparam int NUM_CH = 2;
  localparam int BYTE_W = 8;
  localparam int MAX_W  = 16;
  localparam int ACC_W  = 24;
  localparam int CFG_W  = 5;
  localparam int NREC   = 512;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        enable, fifo_empty, read_enable, data_valid, data_ready, cfg_err;
  logic [NUM_CH*CFG_W-1:0]  cfg_width;
  logic [NUM_CH*BYTE_W-1:0] fifo_data;
  logic [NUM_CH*MAX_W-1:0]  data_out;

  always #5 clk = ~clk;

  sent_tx_data_unpack #(
    .NUM_CH (NUM_CH),
    .BYTE_W (BYTE_W),
    .MAX_W  (MAX_W),
    .ACC_W  (ACC_W),
    .CFG_W  (CFG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_width   (cfg_width),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .read_enable (read_enable),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .cfg_err     (cfg_err)
  );

  // Byte FIFO models: one-cycle read latency.
  logic [7:0]        fmem [NUM_CH][256];
  int unsigned       wr_ptr [NUM_CH];
  int unsigned       rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] hold;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    assign fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]) || hold[c];
  end

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (read_enable[c] && (wr_ptr[c] != rd_ptr[c])) begin
        fifo_data[c*BYTE_W +: BYTE_W] <= fmem[c][rd_ptr[c] % 256];
        rd_ptr[c] <= rd_ptr[c] + 1;
      end
    end
  end

  // Reference: the whole byte stream as a flat bit array; word k is bits
  // [k*w, k*w+w) of that array, first bit most significant.
  logic        sbits [NUM_CH][1024];
  int unsigned slen [NUM_CH], xidx [NUM_CH], mwidth [NUM_CH];
  bit          model_on [NUM_CH];
  int unsigned pops [NUM_CH], nrec [NUM_CH], nerr [NUM_CH];
  logic [MAX_W-1:0] rec [NUM_CH][NREC];
  logic [MAX_W-1:0] prev_data [NUM_CH];
  bit          prev_stall [NUM_CH];

  int unsigned n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [MAX_W-1:0] exp_word(input int c, input int unsigned k);
    logic [MAX_W-1:0] w = '0;
    for (int unsigned j = 0; j < mwidth[c]; j++)
      w = {w[MAX_W-2:0], sbits[c][k*mwidth[c] + j]};
    return w;
  endfunction

  task automatic push_byte(input int c, input logic [7:0] b);
    fmem[c][wr_ptr[c] % 256] = b;
    wr_ptr[c]++;
    for (int i = 7; i >= 0; i--) begin
      if (slen[c] < 1024) sbits[c][slen[c]] = b[i];
      slen[c]++;
    end
  endtask

  task automatic model_start(input int c, input int unsigned w);
    slen[c] = 0;
    xidx[c] = 0;
    mwidth[c] = w;
    model_on[c] = 1'b1;
  endtask

  task automatic monitor();
    for (int c = 0; c < NUM_CH; c++) begin
      logic [MAX_W-1:0] d;
      d = data_out[c*MAX_W +: MAX_W];
      if (!reset) begin
        prev_stall[c] = 1'b0;
      end else begin
        if (read_enable[c]) begin
          pops[c]++;
          chk($sformatf("ch%0d_pop_when_empty", c), fifo_empty[c], 1'b0);
        end
        if (prev_stall[c]) begin
          chk($sformatf("ch%0d_stall_valid", c), data_valid[c], 1'b1);
          chk($sformatf("ch%0d_stall_data", c), d, prev_data[c]);
        end
        if (data_valid[c] && data_ready[c]) begin
          if (nrec[c] < NREC) rec[c][nrec[c]] = d;
          nrec[c]++;
          if (model_on[c]) begin
            chk($sformatf("ch%0d_word_in_stream", c), 32'((xidx[c] + 1) * mwidth[c] <= slen[c]), 1);
            if ((xidx[c] + 1) * mwidth[c] <= slen[c])
              chk($sformatf("ch%0d_model_word%0d", c, xidx[c]), d, exp_word(c, xidx[c]));
            xidx[c]++;
          end
        end
        if (cfg_err[c]) nerr[c]++;
        prev_stall[c] = data_valid[c] && !data_ready[c];
      end
      prev_data[c] = d;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c, input int unsigned w);
    cfg_width[c*CFG_W +: CFG_W] = CFG_W'(w);
  endtask

  task automatic wait_recs(input int c, input int unsigned target);
    for (int t = 0; t < 200; t++) begin
      if (nrec[c] >= target) break;
      step();
    end
  endtask

  typedef struct packed {
    logic [0:0]  ch;
    logic [4:0]  width;
    logic [3:0]  nbytes;
    logic [47:0] bytes;
    logic [2:0]  nwords;
    logic [63:0] words;
    logic [3:0]  npops;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int idx);
    vec_t        v;
    int          c;
    int unsigned p0, r0;
    logic [47:0] bv;
    logic [63:0] wv;
    v  = vecs[idx];
    c  = int'(v.ch);
    bv = v.bytes;
    wv = v.words;
    p0 = pops[c];
    r0 = nrec[c];
    model_on[c]   = 1'b0;
    data_ready[c] = 1'b1;
    set_cfg(c, v.width);
    for (int i = 0; i < int'(v.nbytes); i++) push_byte(c, bv[47-8*i -: 8]);
    enable[c] = 1'b1;
    wait_recs(c, r0 + v.nwords);
    repeat (6) step();
    chk($sformatf("vec%0d_word_count", idx), nrec[c] - r0, 32'(v.nwords));
    for (int i = 0; i < int'(v.nwords); i++)
      chk($sformatf("vec%0d_word%0d", idx, i), rec[c][(r0 + i) % NREC], wv[63-16*i -: 16]);
    chk($sformatf("vec%0d_pops", idx), pops[c] - p0, 32'(v.npops));
    enable[c] = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned p0, r0, e0, e1;
    int unsigned nb [NUM_CH];
    int unsigned ecfg [NUM_CH];
    int unsigned cfgv;
    bit busy;

    vecs[0] = '{1'd0, 5'd14, 4'd2, {8'hA5, 8'h3C, 32'h0}, 3'd1, {16'h294F, 48'h0}, 4'd2};
    vecs[1] = '{1'd0, 5'd14, 4'd4, {32'hA53C0FF0, 16'h0}, 3'd2, {16'h294F, 16'h00FF, 32'h0}, 4'd4};
    vecs[2] = '{1'd0, 5'd12, 4'd3, {24'h123456, 24'h0}, 3'd2, {16'h0123, 16'h0456, 32'h0}, 4'd3};
    vecs[3] = '{1'd0, 5'd10, 4'd5, {40'hFF00FF00FF, 8'h0}, 3'd4, {16'h03FC, 16'h000F, 16'h03C0, 16'h00FF}, 4'd5};
    vecs[4] = '{1'd1, 5'd8,  4'd2, {16'h5AC3, 32'h0}, 3'd2, {16'h005A, 16'h00C3, 32'h0}, 4'd2};
    vecs[5] = '{1'd1, 5'd16, 4'd4, {32'hBEEFCAFE, 16'h0}, 3'd2, {16'hBEEF, 16'hCAFE, 32'h0}, 4'd4};
    vecs[6] = '{1'd1, 5'd9,  4'd3, {24'h814224, 24'h0}, 3'd2, {16'h0102, 16'h0108, 32'h0}, 4'd3};

    reset = 1'b0;
    enable = '0;
    data_ready = '0;
    hold = '0;
    cfg_width = '0;
    set_cfg(0, 8);
    push_byte(0, 8'h77);
    enable = 2'b01;
    repeat (3) step();
    chk("rst_read_enable", read_enable, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_cfg_err", cfg_err, 0);

    data_ready = '1;
    reset = 1'b1;
    r0 = nrec[0];
    wait_recs(0, r0 + 1);
    chk("post_rst_first_word", rec[0][r0 % NREC], 16'h0077);
    enable = '0;
    repeat (2) step();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Backpressure: ready low while the first word waits.
    data_ready[0] = 1'b0;
    set_cfg(0, 16);
    model_start(0, 16);
    p0 = pops[0];
    r0 = nrec[0];
    push_byte(0, 8'hBE); push_byte(0, 8'hEF); push_byte(0, 8'hCA);
    push_byte(0, 8'hFE); push_byte(0, 8'h12); push_byte(0, 8'h34);
    enable[0] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (data_valid[0]) break;
      step();
    end
    chk("bp_first_valid", data_valid[0], 1'b1);
    chk("bp_first_word", data_out[15:0], 16'hBEEF);
    repeat (10) begin
      step();
      chk("bp_hold_word", data_out[15:0], 16'hBEEF);
    end
    chk("bp_pops_stalled", pops[0] - p0, 4);
    data_ready[0] = 1'b1;
    step();
    chk("bp_second_valid", data_valid[0], 1'b1);
    chk("bp_second_word", data_out[15:0], 16'hCAFE);
    wait_recs(0, r0 + 3);
    repeat (4) step();
    chk("bp_third_word", rec[0][(r0 + 2) % NREC], 16'h1234);
    chk("bp_word_count", nrec[0] - r0, 3);
    chk("bp_pops_total", pops[0] - p0, 6);
    enable[0] = 1'b0;
    repeat (2) step();

    // Illegal width on ch0 alongside a byte-wide ch1.
    model_start(0, 16);
    model_start(1, 8);
    e0 = nerr[0];
    e1 = nerr[1];
    r0 = nrec[1];
    set_cfg(0, 20);
    set_cfg(1, 8);
    push_byte(0, 8'h11); push_byte(0, 8'h22); push_byte(0, 8'h33); push_byte(0, 8'h44);
    push_byte(1, 8'h5A); push_byte(1, 8'hC3); push_byte(1, 8'hA5);
    enable = 2'b11;
    step();
    set_cfg(0, 10);
    for (int t = 0; t < 100; t++) begin
      if (xidx[0] >= 2 && xidx[1] >= 3) break;
      step();
    end
    repeat (4) step();
    chk("cfg_err_ch0_pulses", nerr[0] - e0, 1);
    chk("cfg_err_ch1_pulses", nerr[1] - e1, 0);
    chk("cfg_ch0_words", xidx[0], 2);
    chk("cfg_ch1_words", xidx[1], 3);
    chk("cfg_ch1_passthru", rec[1][r0 % NREC], 16'h005A);
    enable = '0;
    model_on[0] = 1'b0;
    model_on[1] = 1'b0;
    repeat (2) step();

    // Disable while a read is in flight.
    set_cfg(0, 16);
    p0 = pops[0];
    push_byte(0, 8'h01); push_byte(0, 8'h02); push_byte(0, 8'h03);
    enable[0] = 1'b1;
    step();
    enable[0] = 1'b0;
    #1;
    chk("dis_read_enable", read_enable[0], 1'b0);
    repeat (2) step();
    chk("dis_pops", pops[0] - p0, 1);
    set_cfg(0, 8);
    r0 = nrec[0];
    enable[0] = 1'b1;
    wait_recs(0, r0 + 2);
    chk("dis_word0", rec[0][r0 % NREC], 16'h0002);
    chk("dis_word1", rec[0][(r0 + 1) % NREC], 16'h0003);
    enable[0] = 1'b0;
    repeat (2) step();

    // Reset mid-word with a byte in flight.
    set_cfg(0, 16);
    push_byte(0, 8'hAA);
    enable[0] = 1'b1;
    repeat (4) step();
    push_byte(0, 8'hBB);
    step();
    reset = 1'b0;
    enable = '0;
    #1;
    chk("midrst_read_enable", read_enable, 0);
    chk("midrst_data_valid", data_valid, 0);
    chk("midrst_data_out", data_out, 0);
    repeat (2) step();
    reset = 1'b1;
    push_byte(0, 8'hCC);
    repeat (3) begin
      step();
      chk("postrst_read_enable", read_enable, 0);
      chk("postrst_data_valid", data_valid, 0);
    end
    set_cfg(0, 8);
    r0 = nrec[0];
    enable[0] = 1'b1;
    wait_recs(0, r0 + 1);
    repeat (3) step();
    chk("postrst_word", rec[0][r0 % NREC], 16'h00CC);
    chk("postrst_word_count", nrec[0] - r0, 1);
    enable = '0;
    repeat (2) step();

    // Randomized streams with random backpressure and FIFO stalls.
    for (int round = 0; round < 4; round++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfgv = $urandom_range(0, 31);
        ecfg[c] = (cfgv >= 8 && cfgv <= 16) ? 0 : 1;
        model_start(c, ecfg[c] != 0 ? 16 : cfgv);
        set_cfg(c, cfgv);
        nb[c] = $urandom_range(10, 30);
        for (int unsigned i = 0; i < nb[c]; i++) push_byte(c, 8'($urandom));
      end
      p0 = pops[0];
      r0 = pops[1];
      e0 = nerr[0];
      e1 = nerr[1];
      enable = '1;
      for (int t = 0; t < 1500; t++) begin
        busy = 1'b0;
        if (xidx[0] < nb[0]*8/mwidth[0] || pops[0] - p0 < nb[0]) busy = 1'b1;
        if (xidx[1] < nb[1]*8/mwidth[1] || pops[1] - r0 < nb[1]) busy = 1'b1;
        if (!busy) break;
        data_ready = NUM_CH'($urandom);
        for (int c = 0; c < NUM_CH; c++) hold[c] = ($urandom_range(0, 4) == 0);
        step();
      end
      data_ready = '1;
      hold = '0;
      repeat (6) step();
      chk($sformatf("rand%0d_ch0_words", round), xidx[0], nb[0]*8/mwidth[0]);
      chk($sformatf("rand%0d_ch1_words", round), xidx[1], nb[1]*8/mwidth[1]);
      chk($sformatf("rand%0d_ch0_pops", round), pops[0] - p0, nb[0]);
      chk($sformatf("rand%0d_ch1_pops", round), pops[1] - r0, nb[1]);
      chk($sformatf("rand%0d_ch0_cfg_err", round), nerr[0] - e0, ecfg[0]);
      chk($sformatf("rand%0d_ch1_cfg_err", round), nerr[1] - e1, ecfg[1]);
      enable = '0;
      repeat (2) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
